// File: rtl/uart_8n1_pkg.sv
// rtl/uart_8n1_pkg.sv - shared constants and types for the 8N1 UART receive buffer
// Contents:
//   DATA_WIDTH  : received frame payload width (8)
//   ENTRY_WIDTH : FIFO entry width, 9 ({error, data}) when UART_RX_BUFFER_ERR_TAG_EN
//                 is defined, otherwise 8 (data only)
//   rx_state_t  : receiver handshake FSM states (IDLE, ARM, RECV)
package uart_8n1_pkg;

  localparam int DATA_WIDTH = 8;

`ifdef UART_RX_BUFFER_ERR_TAG_EN
  localparam int ENTRY_WIDTH = DATA_WIDTH + 1;
`else
  localparam int ENTRY_WIDTH = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RECV = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
// Ports:
//   clk        : clock
//   reset      : synchronous active-high reset
//   clear      : synchronous flush (wins over push/pop in the same cycle)
//   push       : write request; accepted when not full, or when full with a pop this cycle
//   push_data  : entry to write
//   pop        : remove head entry (ignored when empty)
//   head_data  : head entry, forced to 0 while empty
//   valid      : FIFO non-empty
//   full       : FIFO holds 2**DEPTH_LOG2 entries
//   count      : occupancy, 0..2**DEPTH_LOG2
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && valid;
  // When full, a concurrent pop frees the slot at rd_ptr (== wr_ptr), so the
  // new entry lands there and becomes the tail.
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; masking keeps the head at 0 while nothing is queued.
  assign head_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_8n1_rx_buffer.sv
// rtl/uart_8n1_rx_buffer.sv - keeps an 8N1 receiver armed and buffers its frames in a FIFO
// Optional feature macro: UART_RX_BUFFER_ERR_TAG_EN (errored frames stored with an error tag)
// Ports:
//   clk_baud_16x : sole clock (16x baud)
//   reset        : synchronous active-high reset
//   recv_data    : received byte from the receiver
//   recv_busy    : receiver is in a receive cycle
//   recv_error   : receiver frame-error pulse, valid in the capture cycle
//   recv_read    : arm request to the receiver
//   out_data     : head-of-FIFO byte
//   out_error    : head entry error tag (0 when the tag feature is disabled)
//   out_valid    : FIFO non-empty
//   out_ready    : consumer accepts head this cycle
//   fifo_count   : current occupancy
//   overflow     : sticky, a frame was dropped for lack of space
//   err_count    : saturating count of errored frames
//   clear        : synchronous flush of FIFO, overflow and err_count
module uart_8n1_rx_buffer
  import uart_8n1_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_baud_16x,
  input  logic                     reset,
  input  logic [7:0]               recv_data,
  input  logic                     recv_busy,
  input  logic                     recv_error,
  output logic                     recv_read,
  output logic [7:0]               out_data,
  output logic                     out_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH_LOG2:0]      fifo_count,
  output logic                     overflow,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     clear
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  rx_state_t              state;
  logic                   capture;
  logic                   push;
  logic                   fifo_full;
  logic [ENTRY_WIDTH-1:0] push_entry;
  logic [ENTRY_WIDTH-1:0] head_entry;

  // The receiver drops busy once the frame is complete; that cycle carries data/error.
  assign capture = (state == RECV) && !recv_busy;

`ifdef UART_RX_BUFFER_ERR_TAG_EN
  assign push       = capture && !clear;
  assign push_entry = {recv_error, recv_data};
  assign out_error  = head_entry[DATA_WIDTH];
`else
  assign push       = capture && !recv_error && !clear;
  assign push_entry = recv_data;
  assign out_error  = 1'b0;
`endif

  assign out_data = head_entry[DATA_WIDTH-1:0];

  uart_sync_fifo #(
    .WIDTH      (ENTRY_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk_baud_16x),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .head_data (head_entry),
    .valid     (out_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // recv_read is registered alongside the state so it is high exactly in ARM.
  always_ff @(posedge clk_baud_16x) begin
    if (reset) begin
      state     <= IDLE;
      recv_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= ARM;
          recv_read <= 1'b1;
        end
        ARM: begin
          if (recv_busy) begin
            state     <= RECV;
            recv_read <= 1'b0;
          end
        end
        RECV: begin
          if (!recv_busy) begin
            state     <= ARM;
            recv_read <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          recv_read <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_baud_16x) begin
    if (reset || clear) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      // A full FIFO still accepts the push when the head leaves in the same cycle.
      if (push && fifo_full && !out_ready) overflow <= 1'b1;
      if (capture && recv_error && (err_count != '1)) err_count <= err_count + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_uart_8n1_rx_buffer.sv
// tb/tb_uart_8n1_rx_buffer.sv - scoreboard testbench for uart_8n1_rx_buffer
module tb_uart_8n1_rx_buffer;

  localparam int DL  = 4;
  localparam int EW  = 2;
`ifdef UART_RX_BUFFER_ERR_TAG_EN
  localparam int TAG = 1;
`else
  localparam int TAG = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    recv_data = 8'h00;
  logic          recv_busy = 1'b0;
  logic          recv_error = 1'b0;
  logic          recv_read;
  logic [7:0]    out_data;
  logic          out_error;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL:0]   fifo_count;
  logic          overflow;
  logic [EW-1:0] err_count;
  logic          clear = 1'b0;

  always #5 clk = ~clk;

  uart_8n1_rx_buffer #(
    .DEPTH_LOG2    (DL),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .clk_baud_16x (clk),
    .reset        (reset),
    .recv_data    (recv_data),
    .recv_busy    (recv_busy),
    .recv_error   (recv_error),
    .recv_read    (recv_read),
    .out_data     (out_data),
    .out_error    (out_error),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .err_count    (err_count),
    .clear        (clear)
  );

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (!reset && out_valid) begin
      valid_cycles++;
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h expected no entry", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", int'(out_data), int'(e[7:0]));
          chk("pop_error", int'(out_error), int'(e[8]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: wait for arm, go busy, then deliver the frame on busy fall.
  task automatic send_frame(input logic [7:0] d, input logic e,
                            input logic pop_cap, input logic clr_cap);
    int n = 0;
    while (!recv_read && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!recv_read) chk("arm_timeout", int'(recv_read), 1);
    recv_busy = 1'b1;
    cyc(3);
    recv_busy  = 1'b0;
    recv_data  = d;
    recv_error = e;
    if (pop_cap) out_ready = 1'b1;
    if (clr_cap) clear = 1'b1;
    cyc(1);
    recv_error = 1'b0;
    clear      = 1'b0;
    if (pop_cap) out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_recv_read", int'(recv_read), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_error", int'(out_error), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_err_count", int'(err_count), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("release_cycle1_recv_read", int'(recv_read), 0);
    @(negedge clk);
    chk("release_cycle2_recv_read", int'(recv_read), 1);

    // Streaming three good frames straight through
    out_ready    = 1'b1;
    valid_cycles = 0;
    exp_q.push_back({1'b0, 8'h55}); send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("rearm_after_capture", int'(recv_read), 1);
    exp_q.push_back({1'b0, 8'hA3}); send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h0F}); send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    cyc(3);
    @(negedge clk);
    chk("stream_valid_cycles", valid_cycles, 3);
    chk("stream_err_count", int'(err_count), 0);
    chk("stream_queue_drained", exp_q.size(), 0);

    // Overflow: 17 frames into a 16-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back({1'b0, 8'(i)});
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("ovf_fifo_count", int'(fifo_count), 16);
    chk("ovf_overflow", int'(overflow), 1);
    chk("ovf_head_stable", int'(out_data), 1);
    out_ready = 1'b1;
    cyc(20);
    out_ready = 1'b0;
    @(negedge clk);
    chk("ovf_drained_count", int'(fifo_count), 0);
    chk("ovf_drained_queue", exp_q.size(), 0);
    chk("ovf_sticky", int'(overflow), 1);
    pulse_clear();
    @(negedge clk);
    chk("clear_overflow", int'(overflow), 0);

    // Single errored frame
    if (TAG != 0) exp_q.push_back({1'b1, 8'h99});
    send_frame(8'h99, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("errframe_err_count", int'(err_count), 1);
    chk("errframe_fifo_count", int'(fifo_count), TAG);
    out_ready = 1'b1;
    cyc(3);
    out_ready = 1'b0;
    chk("errframe_queue_drained", exp_q.size(), 0);
    pulse_clear();

    // Full FIFO with pop at the capture edge
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 8'h20 + 8'(i)});
      send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("full_fifo_count", int'(fifo_count), 16);
    exp_q.push_back({1'b0, 8'hEE});
    send_frame(8'hEE, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("pushpop_fifo_count", int'(fifo_count), 16);
    chk("pushpop_overflow", int'(overflow), 0);
    chk("pushpop_new_head", int'(out_data), 8'h21);
    out_ready = 1'b1;
    cyc(20);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_drained_queue", exp_q.size(), 0);

    // Capture coinciding with clear is discarded
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_cap_fifo_count", int'(fifo_count), 0);
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_cap_err_count", int'(err_count), 0);

    // Saturating error counter, then clear
    exp_q.push_back({1'b0, 8'h77});
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (TAG != 0) exp_q.push_back({1'b1, 8'hE0 + 8'(i)});
      send_frame(8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("sat_err_count", int'(err_count), 3);
    chk("sat_fifo_count", int'(fifo_count), 1 + 5 * TAG);
    chk("sat_out_valid", int'(out_valid), 1);
    pulse_clear();
    @(negedge clk);
    chk("clear_out_valid", int'(out_valid), 0);
    chk("clear_fifo_count", int'(fifo_count), 0);
    chk("clear_err_count", int'(err_count), 0);
    chk("clear_overflow2", int'(overflow), 0);

    // Reset during a reception
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_pre_count", int'(fifo_count), 1);
    recv_busy = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    recv_busy = 1'b0;
    @(negedge clk);
    chk("midrst_recv_read", int'(recv_read), 0);
    chk("midrst_fifo_count", int'(fifo_count), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(2);
    chk("midrst_rearm", int'(recv_read), 1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
